// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the board UART: frame constants, transmitter state
// encoding and a parity helper.
// Optional build macro: UART_TX_PARITY_EN adds the PARITY state (8E1 frames).
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int CLK_CNT_W = 16;

  typedef enum logic [2:0] {
    s_IDLE,
    s_TX_START_BIT,
    s_TX_DATA_BITS,
`ifdef UART_TX_PARITY_EN
    s_TX_PARITY_BIT,
`endif
    s_TX_STOP_BIT
  } tx_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Small synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous active-high reset, empties the FIFO
//   push_i   write data_i (ignored when full)
//   pop_i    discard head entry (ignored when empty)
//   data_i   write data
//   data_o   head entry, valid while empty_o is 0
//   full_o   count equals DEPTH
//   empty_o  count equals 0
//   count_o  registered occupancy, 0..DEPTH
// DEPTH must be a power of two, at least 2.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full refuses a push even when a pop lands in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// UART transmitter: bytes are queued in a small FIFO and sent as 8N1 frames
// (start, 8 data bits LSB first, stop). Queued bytes follow each other with
// no idle gap. All outputs are registered.
// Optional build macro: UART_TX_PARITY_EN inserts an even-parity bit (8E1).
// Ports:
//   i_Clock      clock, rising edge
//   i_Reset      asynchronous active-high reset; aborts frame, empties FIFO
//   i_Tx_DV      byte-write strobe, accepted only while o_Tx_Ready is 1
//   i_Tx_Byte    byte to send, sampled with i_Tx_DV
//   o_Tx_Ready   FIFO not full
//   o_Tx_Serial  serial line, idles high
//   o_Tx_Active  frame on the line (start through stop bit)
//   o_Tx_Done    one-cycle pulse after each completed frame
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CLK_CNT_W-1:0] CNT_LAST      = CLK_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCW-1:0]       FIFO_FULL_CNT = FCW'(FIFO_DEPTH);
  localparam logic [2:0]           IDX_LAST      = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CLK_CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 serial_q, serial_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic [FCW-1:0]       fifo_count;
  logic                 bit_last;

  assign o_Tx_Ready  = (fifo_count != FIFO_FULL_CNT);
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

  assign fifo_push = i_Tx_DV & ~fifo_full;
  assign bit_last  = (cnt_q == CNT_LAST);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i   (i_Clock),
    .rst_i   (i_Reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (i_Tx_Byte),
    .data_o  (fifo_rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;

    case (state_q)
      s_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          cnt_d    = '0;
          state_d  = s_TX_START_BIT;
        end
      end

      s_TX_START_BIT: begin
        if (bit_last) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = s_TX_DATA_BITS;
        end else begin
          cnt_d = cnt_q + CLK_CNT_W'(1);
        end
      end

      s_TX_DATA_BITS: begin
        if (bit_last) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = s_TX_PARITY_BIT;
`else
            state_d = s_TX_STOP_BIT;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CLK_CNT_W'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      s_TX_PARITY_BIT: begin
        if (bit_last) begin
          cnt_d   = '0;
          state_d = s_TX_STOP_BIT;
        end else begin
          cnt_d = cnt_q + CLK_CNT_W'(1);
        end
      end
`endif

      s_TX_STOP_BIT: begin
        if (bit_last) begin
          cnt_d  = '0;
          done_d = 1'b1;
          // Chain straight into the next start bit to avoid an idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            state_d  = s_TX_START_BIT;
          end else begin
            state_d = s_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CLK_CNT_W'(1);
        end
      end

      default: state_d = s_IDLE;
    endcase
  end

  // Line level is decoded from the next state so it changes on the same edge
  // as the state register.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      s_TX_START_BIT:  serial_d = 1'b0;
      s_TX_DATA_BITS:  serial_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
      s_TX_PARITY_BIT: serial_d = even_parity(shift_d);
`endif
      default:         serial_d = 1'b1;
    endcase
    active_d = (state_d != s_IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= s_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

endmodule
